load_store_unit: RTL and testbench

Memory-access stage directly downstream of the ALU. Takes the ALU `result` as the effective address, together with store data and access size from decode. Runs one data-memory transaction per request over a req/ack bus. Returns sign- or zero-extended load data, or a store completion, to writeback, and tells the core to stall while busy.

---
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage behind the ALU. One data-memory transaction per request
//   over a req/ack bus; returns extended load data or a store completion.
//
//   Optional feature macro: LSU_TIMEOUT_EN (ack watchdog of TIMEOUT cycles).
//   Without it, REQ waits indefinitely and bus_err is tied 0.
//
//   Ports
//     clk, rst                    rising-edge clock, synchronous active-high reset
//     req_valid / req_ready       request handshake from execute
//     req_we, req_size,
//     req_unsigned, addr, wdata   operation, size (00 B, 01 H, 10 W, 11 rsvd),
//                                 zero-extend flag, effective address, store data
//     mem_req/mem_we/mem_addr/
//     mem_wdata/mem_be            bus request side, held stable until mem_ack
//     mem_ack, mem_rdata          bus completion and raw read word
//     rsp_valid                   one-cycle completion pulse to writeback
//     rdata, misaligned, bus_err  registered response, held until next rsp_valid
//     stall                       = !req_ready
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rdata,
  output logic            misaligned,
  output logic            bus_err,
  output logic            stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // The watchdog needs room for at least one wait cycle.
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("load_store_unit: TIMEOUT must be at least 2");
  end

  logic [1:0] state;
  logic       we_q;
  logic       uns_q;
  logic [1:0] size_q;
  logic [1:0] off_q;
  logic       accept;
  logic       timeout_hit;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  // Replicate the low byte/half across every lane so the bus can pick any lane.
  function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size,
                                                 input logic [XLEN-1:0] wd);
    case (size)
      2'b00:   lane_wdata = {(XLEN/8){wd[7:0]}};
      2'b01:   lane_wdata = {(XLEN/16){wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                  input logic [1:0] size,
                                                  input logic [1:0] off,
                                                  input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[{off, 3'b000} +: 8];
    h = off[1] ? raw[31:16] : raw[15:0];
    case (size)
      2'b00:   load_extend = uns ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
      2'b01:   load_extend = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      default: load_extend = raw;
    endcase
  endfunction

  // req_ready is forced low while rst is high so nothing is accepted on the reset edge.
  assign req_ready = (state == S_IDLE) && !rst;
  assign stall     = !req_ready;
  assign accept    = req_valid && req_ready;
  assign mem_req   = (state == S_REQ);
  assign rsp_valid = (state == S_RESP);

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] wd_cnt;

  // Ack in the expiry cycle takes priority over the watchdog.
  assign timeout_hit = (state == S_REQ) && !mem_ack && (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      if (accept)
        wd_cnt <= '0;
      else if ((state == S_REQ) && !mem_ack)
        wd_cnt <= wd_cnt + 1'b1;
      // bus_err only changes on the edge that enters RESP.
      if ((state == S_REQ) && mem_ack)
        bus_err <= 1'b0;
      else if (timeout_hit)
        bus_err <= 1'b1;
      else if (accept && is_misaligned(req_size, addr[1:0]))
        bus_err <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= 4'b0000;
      rdata      <= '0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            off_q     <= addr[1:0];
            mem_we    <= req_we;
            mem_addr  <= {addr[XLEN-1:2], 2'b00};
            mem_wdata <= lane_wdata(req_size, wdata);
            mem_be    <= lane_be(req_size, addr[1:0]);
            if (is_misaligned(req_size, addr[1:0])) begin
              // Fault completes without touching the bus.
              state      <= S_RESP;
              misaligned <= 1'b1;
              rdata      <= '0;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            state      <= S_RESP;
            misaligned <= 1'b0;
            rdata      <= we_q ? '0 : load_extend(mem_rdata, size_q, off_q, uns_q);
          end else if (timeout_hit) begin
            state      <= S_RESP;
            misaligned <= 1'b0;
            rdata      <= '0;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        stall;

  int n_tests;
  int n_fail;

  load_store_unit #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .misaligned(misaligned),
    .bus_err(bus_err), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic [31:0] e_rdata;
  } op_t;

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    addr = a; wdata = wd;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, stall} !== 2'b01) begin
      n_fail++; $display("FAIL reset_ready: ready/stall=%b required 01", {req_ready, stall});
    end
    n_tests++;
    if ({mem_req, mem_we, rsp_valid, misaligned, bus_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 00000",
                         {mem_req, mem_we, rsp_valid, misaligned, bus_err});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, rdata, mem_be} !== 100'b0) begin
      n_fail++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h be=%b required zeros",
                         mem_addr, mem_wdata, rdata, mem_be);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({req_ready, stall} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: ready/stall=%b required 10", {req_ready, stall});
    end
  endtask

  task automatic test_ops;
    op_t ops[8];
    ops[0] = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_7F01, 32'h100, 32'h0, 4'b1000, 32'hFFFF_FF80};
    ops[1] = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_7F01, 32'h100, 32'h0, 4'b1000, 32'h0000_0080};
    ops[2] = '{1'b0, 2'b01, 1'b0, 32'h000, 32'h5555_AAAA, 32'h1234_F00F, 32'h000, 32'hAAAA_AAAA, 4'b0011, 32'hFFFF_F00F};
    ops[3] = '{1'b0, 2'b01, 1'b1, 32'h002, 32'h0, 32'h8001_7F00, 32'h000, 32'h0, 4'b1100, 32'h0000_8001};
    ops[4] = '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0102_0304, 32'hDEAD_BEEF, 32'h010, 32'h0102_0304, 4'b1111, 32'hDEAD_BEEF};
    ops[5] = '{1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00A5, 32'hFFFF_FFFF, 32'h200, 32'hA5A5_A5A5, 4'b0010, 32'h0};
    ops[6] = '{1'b1, 2'b10, 1'b0, 32'h204, 32'hCAFE_F00D, 32'h1111_1111, 32'h204, 32'hCAFE_F00D, 4'b1111, 32'h0};
    ops[7] = '{1'b0, 2'b00, 1'b0, 32'h001, 32'h0, 32'h0000_7F00, 32'h000, 32'h0, 4'b0010, 32'h0000_007F};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1) begin
        n_fail++; $display("FAIL op%0d_ready: req_ready=%b required 1", i, req_ready);
      end
      drive_req(ops[i].we, ops[i].size, ops[i].uns, ops[i].a, ops[i].wd);
      @(negedge clk);
      req_valid = 1'b0;
      n_tests++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, rsp_valid} !==
          {1'b1, ops[i].we, ops[i].e_addr, ops[i].e_wdata, ops[i].e_be, 1'b0}) begin
        n_fail++; $display("FAIL op%0d_bus: req=%b we=%b addr=%h wdata=%h be=%b rsp=%b required 1 %b %h %h %b 0",
                           i, mem_req, mem_we, mem_addr, mem_wdata, mem_be, rsp_valid,
                           ops[i].we, ops[i].e_addr, ops[i].e_wdata, ops[i].e_be);
      end
      mem_ack = 1'b1; mem_rdata = ops[i].rd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
      n_tests++;
      if ({rsp_valid, mem_req, req_ready, misaligned, bus_err} !== 5'b10000) begin
        n_fail++; $display("FAIL op%0d_rsp: rsp/req/ready/mis/err=%b required 10000", i,
                           {rsp_valid, mem_req, req_ready, misaligned, bus_err});
      end
      n_tests++;
      if (rdata !== ops[i].e_rdata) begin
        n_fail++; $display("FAIL op%0d_rdata: rdata=%h required %h", i, rdata, ops[i].e_rdata);
      end
    end
  endtask

  task automatic test_misaligned;
    logic [1:0]  sz[4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] ad[4] = '{32'h301, 32'h301, 32'h300, 32'h302};
    logic        we[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_req(we[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF);
      @(negedge clk);
      req_valid = 1'b0;
      n_tests++;
      if ({rsp_valid, misaligned, mem_req, bus_err} !== 4'b1100) begin
        n_fail++; $display("FAIL mis%0d_rsp: rsp/mis/req/err=%b required 1100", i,
                           {rsp_valid, misaligned, mem_req, bus_err});
      end
      n_tests++;
      if (rdata !== 32'h0) begin
        n_fail++; $display("FAIL mis%0d_rdata: rdata=%h required 00000000", i, rdata);
      end
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, mem_req, req_ready, misaligned} !== 4'b0011) begin
        n_fail++; $display("FAIL mis%0d_after: rsp/req/ready/mis=%b required 0011", i,
                           {rsp_valid, mem_req, req_ready, misaligned});
      end
    end
  endtask

  task automatic test_store_wait;
    int req_cycles = 0;
    int bad = 0;
    @(negedge clk);
    drive_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD);
    @(negedge clk);
    req_valid = 1'b0;
    mem_rdata = 32'h7777_7777;
    for (int k = 0; k < 4; k++) begin
      if (mem_req === 1'b1) req_cycles++;
      if ({mem_we, mem_addr, mem_wdata, mem_be, rsp_valid} !==
          {1'b1, 32'h200, 32'hABCD_ABCD, 4'b1100, 1'b0}) bad++;
      if (k == 3) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    n_tests++;
    if (req_cycles !== 4) begin
      n_fail++; $display("FAIL sh_req_cycles: mem_req cycles=%0d required 4", req_cycles);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL sh_bus_stable: unstable cycles=%0d required 0", bad);
    end
    n_tests++;
    if ({rsp_valid, mem_req, misaligned, bus_err, rdata} !== {4'b1000, 32'h0}) begin
      n_fail++; $display("FAIL sh_rsp: rsp/req/mis/err=%b rdata=%h required 1000 00000000",
                         {rsp_valid, mem_req, misaligned, bus_err}, rdata);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rmid_req: mem_req=%b required 1", mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({mem_req, rsp_valid, req_ready, stall} !== 4'b0001) begin
      n_fail++; $display("FAIL rmid_reset: req/rsp/ready/stall=%b required 0001",
                         {mem_req, rsp_valid, req_ready, stall});
    end
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    mem_ack = 1'b0;
    n_tests++;
    if ({rsp_valid, mem_req, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL rmid_late_ack: rsp/req/ready=%b required 001",
                         {rsp_valid, mem_req, req_ready});
    end
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, mem_req, req_ready, rdata} !== {3'b001, 32'h0}) begin
      n_fail++; $display("FAIL rmid_idle: rsp/req/ready=%b rdata=%h required 001 00000000",
                         {rsp_valid, mem_req, req_ready}, rdata);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    int req_cycles = 0;
    int k = 0;
    int bad = 0;
    @(negedge clk);
    drive_req(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    while (rsp_valid !== 1'b1 && k < 40) begin
      if (mem_req === 1'b1) req_cycles++;
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (req_cycles !== 16) begin
      n_fail++; $display("FAIL to_req_cycles: mem_req cycles=%0d required 16", req_cycles);
    end
    n_tests++;
    if ({rsp_valid, bus_err, mem_req, misaligned, rdata} !== {4'b1100, 32'h0}) begin
      n_fail++; $display("FAIL to_rsp: rsp/err/req/mis=%b rdata=%h required 1100 00000000",
                         {rsp_valid, bus_err, mem_req, misaligned}, rdata);
    end
    @(negedge clk);
    drive_req(1'b0, 2'b10, 1'b0, 32'h504, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      if ({mem_req, rsp_valid} !== 2'b10) bad++;
      if (j == 16) begin
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL to_ack16_wait: bad cycles=%0d required 0", bad);
    end
    n_tests++;
    if ({rsp_valid, bus_err, rdata} !== {2'b10, 32'h1122_3344}) begin
      n_fail++; $display("FAIL to_ack16_rsp: rsp/err=%b rdata=%h required 10 11223344",
                         {rsp_valid, bus_err}, rdata);
    end
  endtask
`else
  task automatic test_no_timeout;
    int bad = 0;
    @(negedge clk);
    drive_req(1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int j = 0; j < 30; j++) begin
      if ({mem_req, rsp_valid, bus_err} !== 3'b100) bad++;
      if (j == 29) begin
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL nto_wait: bad cycles=%0d required 0", bad);
    end
    n_tests++;
    if ({rsp_valid, bus_err, rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL nto_rsp: rsp/err=%b rdata=%h required 10 0badf00d",
                         {rsp_valid, bus_err}, rdata);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_ops();
    test_misaligned();
    test_store_wait();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
